// File: rtl/hopfield_pkg.sv
// Constants, state encoding and helpers shared by the Hopfield spike interface.
package hopfield_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(17) = 5.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int N         = 7;                  // neurons / spike vector width
  localparam int PAT_W     = 4;                  // decoded pattern bits (neurons 0..PAT_W-1)
  localparam int FRAME_LEN = 7;                  // cycles per network scan frame (equals N)
  localparam int WINDOW    = 16;                 // frames integrated per decision
  localparam int THRESH    = 8;                  // count at or above this reads as active
  localparam int CNT_W     = clog2(WINDOW + 1);  // holds 0..WINDOW
  localparam int FC_W      = clog2(FRAME_LEN);   // frame phase counter width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2,
    ST_HOLD   = 2'd3
  } dec_state_t;

endpackage

// File: rtl/spike_window_counter.sv
// Bank of per-neuron spike counters with synchronous clear, a sample enable
// and a combinational threshold compare per neuron.
module spike_window_counter #(
  parameter int N      = 7,
  parameter int CNT_W  = 5,
  parameter int THRESH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         sample_en,
  input  logic [N-1:0] spikes,
  output logic [N-1:0] above
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  logic [CNT_W-1:0] count [N];

  // Counts are bounded by the window length, so plain increments never wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) count[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) count[i] <= '0;
    end else if (sample_en) begin
      for (int i = 0; i < N; i++) count[i] <= count[i] + CNT_W'(spikes[i]);
    end
  end

  // Threshold compare is inclusive: a count equal to THRESH reads as active.
  always_comb begin
    above = '0;
    for (int i = 0; i < N; i++) above[i] = (count[i] >= THR);
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Readout end of the Hopfield spike interface: integrates spikes over a window
// of scan frames, thresholds them into a recalled pattern and hands it off.
//
// Output handshake: a result transfers on any cycle where out_valid and
// out_ready are both high. While out_valid is high, pattern_out, active_count
// and out_valid hold steady until that transfer; out_valid never depends
// combinationally on out_ready.
module spike_rate_decoder
  import hopfield_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     spikes,
  input  logic             learning_enable,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [PAT_W-1:0] pattern_out,
  output logic [2:0]       active_count,
  output logic             out_valid,
  input  logic             out_ready,
  output dec_state_t       dbg_state
);

  dec_state_t       state, next_state;
  logic [FC_W-1:0]  frame_cnt;
  logic [CNT_W-1:0] frames_done;
  logic [N-1:0]     above;
  logic [2:0]       pop;
  logic             frame_end;
  logic             handshake;
  logic             sample_en;
  logic             clear_cnt;
  logic             load_result;

  assign frame_end = (frame_cnt == FC_W'(FRAME_LEN - 1));
  assign handshake = out_valid && out_ready;
  assign busy      = (state == ST_ACCUM) || (state == ST_DECIDE);
  assign dbg_state = state;

  spike_window_counter #(
    .N      (N),
    .CNT_W  (CNT_W),
    .THRESH (THRESH)
  ) u_counters (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear_cnt),
    .sample_en (sample_en),
    .spikes    (spikes),
    .above     (above)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state logic plus counter control strobes.
  always_comb begin
    next_state  = state;
    clear_cnt   = 1'b0;
    sample_en   = 1'b0;
    load_result = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !learning_enable) begin
          next_state = ST_ACCUM;
          clear_cnt  = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (learning_enable) begin
          next_state = ST_IDLE;
          clear_cnt  = 1'b1;
        end else if (frame_end) begin
          // One sample per FRAME_LEN cycles sees every network frame once,
          // whatever the phase relative to the network scan.
          sample_en = 1'b1;
          if (frames_done == CNT_W'(WINDOW - 1)) next_state = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (learning_enable) begin
          next_state = ST_IDLE;
          clear_cnt  = 1'b1;
        end else begin
          load_result = 1'b1;
          next_state  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A pending result survives learning; only the auto-restart is held off.
        if (handshake) begin
          if (continuous && !learning_enable) begin
            next_state = ST_ACCUM;
            clear_cnt  = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Frame phase counter and completed-frame counter for the current window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      frames_done <= '0;
    end else if (clear_cnt) begin
      frame_cnt   <= '0;
      frames_done <= '0;
    end else if (state == ST_ACCUM) begin
      frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
      if (sample_en) frames_done <= frames_done + 1'b1;
    end
  end

  // Number of neurons at or above threshold; at most N = 7 fits in 3 bits.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + 3'(above[i]);
  end

  // Result register and valid flag; an aborted window leaves the last result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_out  <= '0;
      active_count <= '0;
      out_valid    <= 1'b0;
    end else if (load_result) begin
      pattern_out  <= above[PAT_W-1:0];
      active_count <= pop;
      out_valid    <= 1'b1;
    end else if (handshake) begin
      out_valid    <= 1'b0;
    end
  end

endmodule
